// File: rtl/multi_port_writeback_pkg.sv
// Shared types and helpers for the multi-port writeback arbiter.
// Holds the arbitration mode enum, the default port count and width helpers.
package multi_port_writeback_pkg;

  typedef enum logic {
    WB_ARB_FIXED = 1'b0,
    WB_ARB_RR    = 1'b1
  } wb_arb_mode_t;

  localparam int DEFAULT_NUM_WB_PORTS = 2;

  function automatic int ptr_width(input int num_units);
    return (num_units > 1) ? $clog2(num_units) : 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_port_writeback_if.sv
// Bundle of unit result sources and writeback ports.
// master drives unit results; slave is the arbiter.
interface multi_port_writeback_if
  import multi_port_writeback_pkg::*;
#(
  parameter int NUM_WB_UNITS = 5,
  parameter int NUM_WB_PORTS = DEFAULT_NUM_WB_PORTS,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 3
);

  logic [NUM_WB_UNITS-1:0]            unit_done;
  logic [NUM_WB_UNITS*ID_WIDTH-1:0]   unit_id;
  logic [NUM_WB_UNITS*DATA_WIDTH-1:0] unit_rd;
  logic [NUM_WB_UNITS-1:0]            unit_ack;
  logic [NUM_WB_PORTS-1:0]            wb_valid;
  logic [NUM_WB_PORTS*ID_WIDTH-1:0]   wb_id;
  logic [NUM_WB_PORTS*DATA_WIDTH-1:0] wb_data;

  modport master (
    output unit_done, unit_id, unit_rd,
    input  unit_ack, wb_valid, wb_id, wb_data
  );

  modport slave (
    input  unit_done, unit_id, unit_rd,
    output unit_ack, wb_valid, wb_id, wb_data
  );

endinterface

// File: rtl/multi_port_writeback_wb_port_allocator.sv
// Combinational multi-grant allocator: rotate done vector by the pointer,
// peel off the lowest set bit once per port, then rotate grants back.
module wb_port_allocator
  import multi_port_writeback_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = ptr_width(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0]                done,
  input  logic [PTR_W-1:0]                    rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_UNITS-1:0] grant,
  output logic                                any_grant,
  output logic [PTR_W-1:0]                    last_idx
);

  logic [2*NUM_UNITS-1:0]               done_dbl;
  logic [NUM_PORTS:0][NUM_UNITS-1:0]    remain;
  logic [NUM_PORTS-1:0][NUM_UNITS-1:0]  grant_rot;

  // Doubling the vector turns the modulo rotation into a plain shift.
  assign done_dbl  = {done, done} >> rr_ptr;
  assign remain[0] = done_dbl[NUM_UNITS-1:0];
  assign any_grant = |done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [2*NUM_UNITS-1:0] grant_dbl;

      assign grant_rot[gi]  = remain[gi] & (~remain[gi] + NUM_UNITS'(1));
      assign remain[gi+1]   = remain[gi] & ~grant_rot[gi];
      assign grant_dbl      = {grant_rot[gi], grant_rot[gi]} << rr_ptr;
      assign grant[gi]      = grant_dbl[2*NUM_UNITS-1:NUM_UNITS];
    end
  endgenerate

  // Grants are packed, so the highest granted port holds the last unit in order.
  always_comb begin
    last_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (grant[p][u]) begin
          last_idx = PTR_W'(u);
        end
      end
    end
  end

endmodule

// File: rtl/multi_port_writeback.sv
// Commits up to NUM_WB_PORTS unit results per cycle through registered
// writeback packets; fixed-priority or round-robin arbitration.
module multi_port_writeback
  import multi_port_writeback_pkg::*;
#(
  parameter int NUM_WB_UNITS = 5,
  parameter int NUM_WB_PORTS = DEFAULT_NUM_WB_PORTS,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 3,
  parameter int ARB_MODE     = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_port_writeback_if.slave bus
);

  localparam int PORTS_EFF = min_int(NUM_WB_PORTS, NUM_WB_UNITS);
  localparam int PTR_W     = ptr_width(NUM_WB_UNITS);
  localparam wb_arb_mode_t MODE = (ARB_MODE == 0) ? WB_ARB_FIXED : WB_ARB_RR;

  typedef struct packed {
    logic                  valid;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } wb_packet_t;

  logic [PTR_W-1:0]                      rr_ptr_reg;
  logic [PTR_W-1:0]                      rr_ptr_next;
  logic [PTR_W-1:0]                      alloc_ptr;
  logic [PORTS_EFF-1:0][NUM_WB_UNITS-1:0] grant;
  logic                                  any_grant;
  logic [PTR_W-1:0]                      last_idx;
  logic [NUM_WB_UNITS-1:0]               ack;

  assign alloc_ptr = (MODE == WB_ARB_RR) ? rr_ptr_reg : '0;

  wb_port_allocator #(
    .NUM_UNITS (NUM_WB_UNITS),
    .NUM_PORTS (PORTS_EFF),
    .PTR_W     (PTR_W)
  ) u_alloc (
    .done      (bus.unit_done),
    .rr_ptr    (alloc_ptr),
    .grant     (grant),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  always_comb begin
    ack = '0;
    for (int p = 0; p < PORTS_EFF; p++) begin
      ack = ack | grant[p];
    end
  end

  // No handshake completes while reset is held, even between edges.
  assign bus.unit_ack = rst_n ? ack : '0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (MODE == WB_ARB_RR && any_grant) begin
      rr_ptr_next = (last_idx == PTR_W'(NUM_WB_UNITS - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WB_PORTS; gi++) begin : g_port
      if (gi < PORTS_EFF) begin : g_live
        wb_packet_t pkt_reg;
        wb_packet_t pkt_next;

        // Ungranted ports drop valid but keep id/data to avoid toggling.
        always_comb begin
          pkt_next       = pkt_reg;
          pkt_next.valid = |grant[gi];
          for (int u = 0; u < NUM_WB_UNITS; u++) begin
            if (grant[gi][u]) begin
              pkt_next.id   = bus.unit_id[u*ID_WIDTH +: ID_WIDTH];
              pkt_next.data = bus.unit_rd[u*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            pkt_reg <= '0;
          end else begin
            pkt_reg <= pkt_next;
          end
        end

        assign bus.wb_valid[gi]                        = pkt_reg.valid;
        assign bus.wb_id[gi*ID_WIDTH +: ID_WIDTH]       = pkt_reg.id;
        assign bus.wb_data[gi*DATA_WIDTH +: DATA_WIDTH] = pkt_reg.data;
      end else begin : g_tied
        assign bus.wb_valid[gi]                        = 1'b0;
        assign bus.wb_id[gi*ID_WIDTH +: ID_WIDTH]       = '0;
        assign bus.wb_data[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_multi_port_writeback.sv
// Bench for multi_port_writeback: a round-robin and a fixed-priority instance
// share stimulus and are compared against an order-list reference model.
module tb_multi_port_writeback;
  import multi_port_writeback_pkg::*;

  localparam int N  = 5;
  localparam int P  = 2;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    done_drv;
  logic [N*IW-1:0] id_drv;
  logic [N*DW-1:0] rd_drv;

  multi_port_writeback_if #(.NUM_WB_UNITS(N), .NUM_WB_PORTS(P), .DATA_WIDTH(DW), .ID_WIDTH(IW)) rr_bus ();
  multi_port_writeback_if #(.NUM_WB_UNITS(N), .NUM_WB_PORTS(P), .DATA_WIDTH(DW), .ID_WIDTH(IW)) fx_bus ();

  assign rr_bus.unit_done = done_drv;
  assign rr_bus.unit_id   = id_drv;
  assign rr_bus.unit_rd   = rd_drv;
  assign fx_bus.unit_done = done_drv;
  assign fx_bus.unit_id   = id_drv;
  assign fx_bus.unit_rd   = rd_drv;

  multi_port_writeback #(
    .NUM_WB_UNITS(N), .NUM_WB_PORTS(P), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ARB_MODE(1)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_bus)
  );

  multi_port_writeback #(
    .NUM_WB_UNITS(N), .NUM_WB_PORTS(P), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ARB_MODE(0)
  ) u_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fx_bus)
  );

  // Reference state: index 0 = round-robin instance, 1 = fixed instance.
  int             rr_ptr_m;
  logic [P-1:0]   exp_valid [2];
  logic [IW-1:0]  exp_id    [2][P];
  logic [DW-1:0]  exp_data  [2][P];
  int             total = 0;
  int             bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Walk the priority order starting at ptr and take the first P done units.
  function automatic void pick(input logic [N-1:0] d, input int ptr, output int sel [P], output int cnt);
    cnt = 0;
    for (int k = 0; k < P; k++) sel[k] = -1;
    for (int k = 0; k < N; k++) begin
      int u;
      u = (ptr + k) % N;
      if (d[u] && cnt < P) begin
        sel[cnt] = u;
        cnt++;
      end
    end
  endfunction

  task automatic clear_model();
    rr_ptr_m = 0;
    for (int m = 0; m < 2; m++) begin
      exp_valid[m] = '0;
      for (int p = 0; p < P; p++) begin
        exp_id[m][p]   = '0;
        exp_data[m][p] = '0;
      end
    end
  endtask

  task automatic load_exp(input int m, input int sel [P], input int cnt);
    for (int p = 0; p < P; p++) begin
      if (p < cnt) begin
        exp_valid[m][p] = 1'b1;
        exp_id[m][p]    = id_drv[sel[p]*IW +: IW];
        exp_data[m][p]  = rd_drv[sel[p]*DW +: DW];
      end else begin
        exp_valid[m][p] = 1'b0;
      end
    end
  endtask

  task automatic check_wb(input string nm, input int m, input logic [P-1:0] v,
                          input logic [P*IW-1:0] ids, input logic [P*DW-1:0] dat);
    chk({nm, "_valid"}, 64'(v), 64'(exp_valid[m]));
    for (int p = 0; p < P; p++) begin
      chk($sformatf("%s_id%0d", nm, p), 64'(ids[p*IW +: IW]), 64'(exp_id[m][p]));
      chk($sformatf("%s_data%0d", nm, p), 64'(dat[p*DW +: DW]), 64'(exp_data[m][p]));
    end
  endtask

  // One arbitration cycle: check acks before the edge, packets after it.
  task automatic run_cycle(output logic [N-1:0] ack_obs);
    int sel_rr [P];
    int sel_fx [P];
    int cnt_rr;
    int cnt_fx;
    logic [N-1:0] ack_rr;
    logic [N-1:0] ack_fx;
    #1;
    pick(done_drv, rr_ptr_m, sel_rr, cnt_rr);
    pick(done_drv, 0, sel_fx, cnt_fx);
    ack_rr = '0;
    ack_fx = '0;
    for (int p = 0; p < cnt_rr; p++) ack_rr[sel_rr[p]] = 1'b1;
    for (int p = 0; p < cnt_fx; p++) ack_fx[sel_fx[p]] = 1'b1;
    ack_obs = rr_bus.unit_ack;
    chk("ack_rr", 64'(rr_bus.unit_ack), 64'(ack_rr));
    chk("ack_fx", 64'(fx_bus.unit_ack), 64'(ack_fx));
    $display("cycle done=%b ack_rr=%b ack_fx=%b ptr=%0d", done_drv, rr_bus.unit_ack, fx_bus.unit_ack, rr_ptr_m);
    @(posedge clk);
    #1;
    load_exp(0, sel_rr, cnt_rr);
    load_exp(1, sel_fx, cnt_fx);
    if (cnt_rr > 0) rr_ptr_m = (sel_rr[cnt_rr-1] + 1) % N;
    check_wb("rr", 0, rr_bus.wb_valid, rr_bus.wb_id, rr_bus.wb_data);
    check_wb("fx", 1, fx_bus.wb_valid, fx_bus.wb_id, fx_bus.wb_data);
  endtask

  // Drop reset between edges and confirm outputs clear without a clock.
  task automatic do_async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid_rr", 64'(rr_bus.wb_valid), 64'(0));
    chk("arst_valid_fx", 64'(fx_bus.wb_valid), 64'(0));
    chk("arst_data_rr", 64'(rr_bus.wb_data[DW-1:0]), 64'(0));
    chk("arst_ack_rr", 64'(rr_bus.unit_ack), 64'(0));
    chk("arst_ack_fx", 64'(fx_bus.unit_ack), 64'(0));
    $display("async reset asserted done=%b", done_drv);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 64'(rr_bus.wb_valid), 64'(0));
    chk("arst_hold_ack", 64'(rr_bus.unit_ack), 64'(0));
    #2 rst_n = 1'b1;
    clear_model();
  endtask

  task automatic set_unit(input int u, input logic [IW-1:0] id, input logic [DW-1:0] data);
    id_drv[u*IW +: IW] = id;
    rd_drv[u*DW +: DW] = data;
  endtask

  initial begin
    logic [N-1:0] obs;
    logic [N-1:0] pend;
    int ack_cnt [N];
    int last_ack [N];
    int max_wait;

    rst_n    = 1'b0;
    done_drv = '1;
    id_drv   = '0;
    rd_drv   = '0;
    clear_model();
    for (int i = 0; i < N; i++) set_unit(i, IW'(i), {8'(8'hA0 + i), 24'($urandom)});

    // Reset with every unit done: no acks, no packets.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_rr", 64'(rr_bus.unit_ack), 64'(0));
    chk("rst_ack_fx", 64'(fx_bus.unit_ack), 64'(0));
    chk("rst_valid", 64'(rr_bus.wb_valid), 64'(0));
    chk("rst_id", 64'(rr_bus.wb_id), 64'(0));
    chk("rst_data", 64'(rr_bus.wb_data), 64'(0));
    #3 rst_n = 1'b1;

    run_cycle(obs);
    chk("rel_ack_01", 64'(obs), 64'(5'b00011));
    chk("rel_valid", 64'(rr_bus.wb_valid), 64'(2'b11));
    chk("rel_id0", 64'(rr_bus.wb_id[0 +: IW]), 64'(0));
    chk("rel_id1", 64'(rr_bus.wb_id[IW +: IW]), 64'(1));

    // Fixed priority: units 1,2 beat unit 4 until they drop.
    done_drv = 5'b10110;
    run_cycle(obs);
    chk("fx_ack_0110", 64'(fx_bus.unit_ack), 64'(5'b00110));
    chk("fx_port0_u1", 64'(fx_bus.wb_id[0 +: IW]), 64'(1));
    chk("fx_port1_u2", 64'(fx_bus.wb_id[IW +: IW]), 64'(2));
    run_cycle(obs);
    done_drv = 5'b10000;
    run_cycle(obs);

    // Single done, then round-robin wrap from pointer 4.
    done_drv = 5'b01000;
    run_cycle(obs);
    chk("single_valid", 64'(rr_bus.wb_valid), 64'(2'b01));
    done_drv = 5'b10001;
    run_cycle(obs);
    chk("wrap_ack", 64'(obs), 64'(5'b10001));
    chk("wrap_port0_u4", 64'(rr_bus.wb_id[0 +: IW]), 64'(4));
    chk("wrap_port1_u0", 64'(rr_bus.wb_id[IW +: IW]), 64'(0));
    done_drv = 5'b00101;
    run_cycle(obs);
    chk("ptr1_port0_u2", 64'(rr_bus.wb_id[0 +: IW]), 64'(2));
    done_drv = '0;
    run_cycle(obs);

    // Fairness with every unit continuously done.
    done_drv = '1;
    max_wait = 0;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i]  = 0;
      last_ack[i] = -1;
    end
    for (int c = 0; c < 10; c++) begin
      run_cycle(obs);
      for (int i = 0; i < N; i++) begin
        if (obs[i]) begin
          ack_cnt[i]++;
          if (c - last_ack[i] - 1 > max_wait) max_wait = c - last_ack[i] - 1;
          last_ack[i] = c;
        end
      end
    end
    for (int i = 0; i < N; i++) chk($sformatf("fair_cnt_u%0d", i), 64'(ack_cnt[i]), 64'(4));
    chk("fair_wait_le2", 64'(max_wait <= 2), 64'(1));

    // Async reset mid-stream, then held units re-arbitrated from pointer 0.
    run_cycle(obs);
    chk("pre_arst_valid", 64'(rr_bus.wb_valid), 64'(2'b11));
    done_drv = 5'b11100;
    do_async_reset();
    run_cycle(obs);
    chk("post_arst_ack", 64'(obs), 64'(5'b01100));

    // Randomized traffic obeying the hold-until-ack handshake.
    pend = done_drv;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_unit(i, IW'($urandom), DW'($urandom));
        end
      end
      done_drv = pend;
      run_cycle(obs);
      pend = pend & ~obs;
      if ($urandom_range(0, 63) == 0) do_async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
